calc_entry_ctrl: RTL

//  Keyboard-driven sequencer for the two-digit BCD arithmetic datapath.

---
 rtl/calc_entry_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/calc_entry_ctrl.sv
// rtl/calc_entry_ctrl.sv - keyboard sequencer for the 2-digit BCD ALU; optional BACKSPACE_EN adds BKSP (066)
module calc_entry_ctrl #(
  parameter int WAIT_TIMEOUT = 50000,
  parameter int TO_W         = 16
) (
  input  logic         fcrystal,
  input  logic         rst_n,
  input  logic [8:0]   last_change,
  input  logic [511:0] key_down,
  input  logic         key_valid,
  input  logic         alu_done,
  output logic [7:0]   op_a,
  output logic [7:0]   op_b,
  output logic [1:0]   op_sel,
  output logic         alu_start,
  output logic [1:0]   disp_sel,
  output logic         busy,
  output logic         err
);

  typedef enum logic [1:0] {S_A, S_B, S_WAIT, S_SHOW} state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(WAIT_TIMEOUT - 1);

  state_t          state;
  logic [TO_W-1:0] counter;
  logic            press;
  logic            is_digit;
  logic [3:0]      digit;
  logic            is_op;
  logic [1:0]      op_code;
  logic            is_enter;
  logic            is_esc;
`ifdef BACKSPACE_EN
  logic            is_bksp;
`endif

  // Only a key going down counts; a release clears its key_down bit before the pulse.
  assign press = key_valid & key_down[last_change];

  // Classify the current press into digit / operator / control key.
  always_comb begin
    is_digit = 1'b0;
    digit    = 4'd0;
    is_op    = 1'b0;
    op_code  = 2'b00;
    is_enter = 1'b0;
    is_esc   = 1'b0;
`ifdef BACKSPACE_EN
    is_bksp  = 1'b0;
`endif
    if (press) begin
      case (last_change)
        9'h045, 9'h070: begin is_digit = 1'b1; digit = 4'd0; end
        9'h016, 9'h069: begin is_digit = 1'b1; digit = 4'd1; end
        9'h01E, 9'h072: begin is_digit = 1'b1; digit = 4'd2; end
        9'h026, 9'h07A: begin is_digit = 1'b1; digit = 4'd3; end
        9'h025, 9'h06B: begin is_digit = 1'b1; digit = 4'd4; end
        9'h02E, 9'h073: begin is_digit = 1'b1; digit = 4'd5; end
        9'h036, 9'h074: begin is_digit = 1'b1; digit = 4'd6; end
        9'h03D, 9'h06C: begin is_digit = 1'b1; digit = 4'd7; end
        9'h03E, 9'h075: begin is_digit = 1'b1; digit = 4'd8; end
        9'h046, 9'h07D: begin is_digit = 1'b1; digit = 4'd9; end
        9'h079:         begin is_op = 1'b1; op_code = 2'b00; end
        9'h07B:         begin is_op = 1'b1; op_code = 2'b01; end
        9'h07C:         begin is_op = 1'b1; op_code = 2'b10; end
        9'h05A, 9'h15A: is_enter = 1'b1;
        9'h076:         is_esc = 1'b1;
`ifdef BACKSPACE_EN
        9'h066:         is_bksp = 1'b1;
`endif
        default: ;
      endcase
    end
  end

  // Entry state machine; all outputs registered, ESC overrides everything.
  always_ff @(posedge fcrystal or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_A;
      op_a      <= 8'h00;
      op_b      <= 8'h00;
      op_sel    <= 2'b00;
      alu_start <= 1'b0;
      disp_sel  <= 2'b00;
      busy      <= 1'b0;
      err       <= 1'b0;
      counter   <= '0;
    end else begin
      alu_start <= 1'b0;
      if (is_esc) begin
        state    <= S_A;
        op_a     <= 8'h00;
        op_b     <= 8'h00;
        op_sel   <= 2'b00;
        disp_sel <= 2'b00;
        busy     <= 1'b0;
        err      <= 1'b0;
        counter  <= '0;
      end else begin
        case (state)
          S_A: begin
            if (is_digit) begin
              op_a <= {op_a[3:0], digit};
              err  <= 1'b0;
            end else if (is_op) begin
              op_sel   <= op_code;
              op_b     <= 8'h00;
              disp_sel <= 2'b01;
              state    <= S_B;
            end
`ifdef BACKSPACE_EN
            else if (is_bksp) op_a <= {4'd0, op_a[7:4]};
`endif
          end
          S_B: begin
            if (is_digit) begin
              op_b <= {op_b[3:0], digit};
              err  <= 1'b0;
            end else if (is_op) begin
              op_sel <= op_code;
            end else if (is_enter) begin
              alu_start <= 1'b1;
              counter   <= '0;
              busy      <= 1'b1;
              state     <= S_WAIT;
            end
`ifdef BACKSPACE_EN
            else if (is_bksp) op_b <= {4'd0, op_b[7:4]};
`endif
          end
          S_WAIT: begin
            if (alu_done) begin
              disp_sel <= 2'b10;
              busy     <= 1'b0;
              state    <= S_SHOW;
            end else if (counter == TO_LAST) begin
              err      <= 1'b1;
              disp_sel <= 2'b11;
              busy     <= 1'b0;
              state    <= S_SHOW;
            end else begin
              counter <= counter + 1'b1;
            end
          end
          S_SHOW: begin
            if (is_digit) begin
              op_a     <= {4'd0, digit};
              op_b     <= 8'h00;
              op_sel   <= 2'b00;
              err      <= 1'b0;
              disp_sel <= 2'b00;
              state    <= S_A;
            end else if (is_op) begin
              op_sel   <= op_code;
              op_b     <= 8'h00;
              disp_sel <= 2'b01;
              state    <= S_B;
            end
          end
          default: state <= S_A;
        endcase
      end
    end
  end

endmodule
